// File: rtl/pe_sched_pkg.sv
// Shared state encoding, PE latency constants and counter sizing for the PE chain sequencer.
package pe_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FIN    = 3'd4
  } sched_state_e;

  localparam int PE_FWD_LAT = 2;
  localparam int PE_OUT_LAT = 2;

  // Wide enough for NUM_PE strobes per pixel plus one spare bit for over-counting.
  function automatic int done_cnt_w(input int pix_cnt_w, input int num_pe);
    return pix_cnt_w + $clog2(num_pe) + 1;
  endfunction

endpackage

// File: rtl/pe_en_delay_line.sv
// Delays the PE0 enable along the chain so PE k is enabled when the forwarded pixel arrives.
module pe_en_delay_line
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en_in,
  output logic [NUM_PE-1:0] taps,
  output logic              empty
);
  localparam int DEPTH = PE_FWD_LAT * (NUM_PE - 1);

  assign taps[0] = en_in;

  generate
    if (DEPTH == 0) begin : g_single
      assign empty = ~en_in;
    end else begin : g_shift
      logic [DEPTH-1:0] sr_q, sr_d;

      always_comb begin
        sr_d = DEPTH'({sr_q, en_in});
        if (clr) sr_d = '0;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sr_q <= '0;
        else       sr_q <= sr_d;
      end

      for (genvar gi = 1; gi < NUM_PE; gi++) begin : g_tap
        assign taps[gi] = sr_q[gi*PE_FWD_LAT-1];
      end

      assign empty = ~en_in & ~(|sr_q);
    end
  endgenerate

endmodule

// File: rtl/pe_chain_sched.sv
// Sequencer for a 1-D multiply PE chain: loads per-PE weights, streams pixels into PE0, aligns
// per-PE enables to the forwarding delay and checks completions. Option: PE_CHAIN_SCHED_PERF_EN.
module pe_chain_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE       = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PIX_CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           abort,
  input  logic [PIX_CNT_W-1:0]           cfg_num_pix,
  output logic                           busy,
  output logic                           done,
  output logic                           done_mismatch,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [WEIGHT_WIDTH-1:0]        w_data,
  input  logic                           px_valid,
  output logic                           px_ready,
  input  logic [DATA_WIDTH-1:0]          px_data,
  output logic [DATA_WIDTH-1:0]          pe_input,
  output logic [NUM_PE*WEIGHT_WIDTH-1:0] pe_weight,
  output logic [NUM_PE-1:0]              pe_en,
`ifdef PE_CHAIN_SCHED_PERF_EN
  output logic [31:0]                    perf_cycles,
  output logic [31:0]                    perf_stalls,
`endif
  input  logic [NUM_PE-1:0]              pe_done_i
);
  localparam int CW  = done_cnt_w(PIX_CNT_W, NUM_PE);
  localparam int WCW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int DCW = $clog2(PE_OUT_LAT + 1);

  sched_state_e            state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [PIX_CNT_W-1:0]    pix_cnt_q, pix_cnt_d, num_pix_q, num_pix_d;
  logic [CW-1:0]           done_cnt_q, done_cnt_d, done_inc, exp_cnt;
  logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;
  logic                    en0_q, en0_d;
  logic [DATA_WIDTH-1:0]   pe_input_q, pe_input_d;
  logic [WEIGHT_WIDTH-1:0] bank_q [NUM_PE];
  logic [WEIGHT_WIDTH-1:0] bank_d [NUM_PE];
  logic                    w_fire, px_fire, dl_empty;

  // Ready is withheld during abort so nothing is consumed by a job that is being thrown away.
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign w_ready       = (state_q == LOAD_W) && !abort;
  assign px_ready      = (state_q == STREAM) && !abort;
  assign w_fire        = w_valid && w_ready;
  assign px_fire       = px_valid && px_ready;
  assign exp_cnt       = CW'(num_pix_q) * CW'(NUM_PE);
  assign done_mismatch = done && (done_cnt_q != exp_cnt);
  assign pe_input      = pe_input_q;

  always_comb begin
    done_inc = '0;
    for (int k = 0; k < NUM_PE; k++) done_inc = done_inc + CW'(pe_done_i[k]);
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pix_cnt_d   = pix_cnt_q;
    num_pix_d   = num_pix_q;
    done_cnt_d  = done_cnt_q + done_inc;
    drain_cnt_d = drain_cnt_q;
    en0_d       = 1'b0;
    pe_input_d  = pe_input_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_pix_d   = cfg_num_pix;
          done_cnt_d  = '0;
          wcnt_d      = '0;
          pix_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = (cfg_num_pix == '0) ? FIN : LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_fire) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_q == WCW'(NUM_PE - 1)) state_d = STREAM;
        end
      end
      STREAM: begin
        if (px_fire) begin
          en0_d      = 1'b1;
          pe_input_d = px_data;
          pix_cnt_d  = pix_cnt_q + PIX_CNT_W'(1);
          if (pix_cnt_q == num_pix_q - PIX_CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Count cycles only once every enable has left the chain, then allow PE output latency.
        if (!dl_empty) drain_cnt_d = '0;
        else if (drain_cnt_q == DCW'(PE_OUT_LAT - 1)) state_d = FIN;
        else drain_cnt_d = drain_cnt_q + DCW'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      en0_d   = 1'b0;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (w_fire) bank_d[wcnt_q] = w_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      pix_cnt_q   <= '0;
      num_pix_q   <= '0;
      done_cnt_q  <= '0;
      drain_cnt_q <= '0;
      en0_q       <= 1'b0;
      pe_input_q  <= '0;
      for (int k = 0; k < NUM_PE; k++) bank_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pix_cnt_q   <= pix_cnt_d;
      num_pix_q   <= num_pix_d;
      done_cnt_q  <= done_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      en0_q       <= en0_d;
      pe_input_q  <= pe_input_d;
      bank_q      <= bank_d;
    end
  end

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_weight
    assign pe_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bank_q[gi];
  end

  pe_en_delay_line #(.NUM_PE(NUM_PE)) u_delay (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (abort),
    .en_in (en0_q),
    .taps  (pe_en),
    .empty (dl_empty)
  );

`ifdef PE_CHAIN_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        perf_cycles_d = '0;
        perf_stalls_d = '0;
      end
    end else begin
      if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == STREAM && !px_valid && perf_stalls_q != '1)
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_pe_chain_sched.sv
// Scoreboard bench for pe_chain_sched: pixel and job-end expectations are queued on acceptance
// and retired when the DUT enables PE0 or pulses done. Covers PE_CHAIN_SCHED_PERF_EN when defined.
module tb_pe_chain_sched;
  localparam int NUM_PE = 4;
  localparam int DW     = 8;
  localparam int WW     = 8;
  localparam int PCW    = 16;

  logic                 clk, rstn, start, abort;
  logic [PCW-1:0]       cfg_num_pix;
  logic                 busy, done, done_mismatch;
  logic                 w_valid, w_ready, px_valid, px_ready;
  logic [WW-1:0]        w_data;
  logic [DW-1:0]        px_data, pe_input;
  logic [NUM_PE*WW-1:0] pe_weight;
  logic [NUM_PE-1:0]    pe_en, pe_done_i;
`ifdef PE_CHAIN_SCHED_PERF_EN
  logic [31:0]          perf_cycles, perf_stalls;
`endif

  pe_chain_sched #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PIX_CNT_W(PCW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cfg_num_pix(cfg_num_pix),
    .busy(busy), .done(done), .done_mismatch(done_mismatch),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .pe_input(pe_input), .pe_weight(pe_weight), .pe_en(pe_en),
`ifdef PE_CHAIN_SCHED_PERF_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .pe_done_i(pe_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE row model: each PE strobes done two cycles after its enable; optionally drops one strobe.
  logic [NUM_PE-1:0] d1, d2;
  logic              drop_req, dropped;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= '0; d2 <= '0; dropped <= 1'b0;
    end else begin
      d1 <= pe_en;
      if (drop_req && !dropped && |d1) begin
        d2 <= d1 & (d1 - NUM_PE'(1));
        dropped <= 1'b1;
      end else begin
        d2 <= d1;
        if (!drop_req) dropped <= 1'b0;
      end
    end
  end
  assign pe_done_i = d2;

  int n_vec, n_err;
  logic [DW-1:0] pix_q[$];
  bit            done_q[$];
  int strobes, rdy_cyc, en_cyc, stall_cyc, busy_cyc, done_cnt;
  logic [NUM_PE*WW-1:0] exp_w;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [2*NUM_PE-1:0] hist;
    bit abort_prev;
    hist = '0;
    abort_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hist = '0;
        continue;
      end
      if (abort_prev) hist = '0;
      hist = {hist[2*NUM_PE-2:0], pe_en[0]};
      for (int k = 1; k < NUM_PE; k++)
        if (hist[2*k] || pe_en[k]) check_eq($sformatf("pe_en%0d_align", k), 64'(pe_en[k]), 64'(hist[2*k]));
      if (pe_en[0]) begin
        if (pix_q.size() == 0) check_eq("pix_extra", 64'd1, 64'd0);
        else check_eq("pe_input", 64'(pe_input), 64'(pix_q.pop_front()));
      end
      if (px_valid && px_ready) pix_q.push_back(px_data);
      strobes += $countones(pe_done_i);
      if (w_ready || px_ready) rdy_cyc++;
      if (|pe_en) en_cyc++;
      if (px_ready && !px_valid) stall_cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) check_eq("done_extra", 64'd1, 64'd0);
        else check_eq("done_mismatch", 64'(done_mismatch), 64'(done_q.pop_front()));
      end
      if (start && !busy && !abort) begin
        done_q.push_back((cfg_num_pix != '0) && drop_req);
        strobes = 0; rdy_cyc = 0; en_cyc = 0; stall_cyc = 0; busy_cyc = 0; done_cnt = 0;
      end
      if (abort && busy && done_q.size() > 0) void'(done_q.pop_back());
      abort_prev = abort;
    end
  endtask

  task automatic run_job(input int n, input bit stall, input bit drop, input int abort_after,
                         input bit poke, input int wbase);
    int wi, pi, guard;
    logic [WW-1:0] wts[NUM_PE];
    for (int k = 0; k < NUM_PE; k++) wts[k] = WW'(wbase + k + 1);
    drop_req = drop;
    cfg_num_pix = PCW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_pix = 16'hBEEF;
    if (n == 0) begin
      @(negedge clk);
      check_eq("zero_done_lat", 64'(done), 64'd1);
    end
    wi = 0; guard = 0;
    while (n != 0 && wi < NUM_PE && guard < 100) begin
      w_valid = !(stall && guard[0]);
      w_data  = wts[wi];
      @(negedge clk);
      if (w_valid && w_ready) wi++;
      @(posedge clk); #1;
      guard++;
    end
    w_valid = 1'b0;
    if (n != 0) begin
      check_eq("w_load_beats", 64'(wi), 64'(NUM_PE));
      for (int k = 0; k < NUM_PE; k++) exp_w[k*WW +: WW] = wts[k];
    end
    pi = 0; guard = 0;
    while (n != 0 && pi < n && guard < 200) begin
      if (abort_after != 0 && pi == abort_after) break;
      px_valid = !(stall && guard[0]);
      px_data  = DW'(10 * (pi + 1));
      start    = poke && (guard == 2);
      @(negedge clk);
      if (px_valid && px_ready) pi++;
      @(posedge clk); #1;
      guard++;
    end
    px_valid = 1'b0;
    start = 1'b0;
    if (abort_after != 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_pe_en", 64'(pe_en), 64'd0);
      check_eq("abort_ready", 64'({w_ready, px_ready}), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      check_eq("abort_no_done", 64'(done_cnt), 64'd0);
    end else begin
      guard = 0;
      while (done_cnt == 0 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      check_eq("done_timeout", 64'(guard < 100), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_pulses", 64'(done_cnt), 64'd1);
      check_eq("pe_strobes", 64'(strobes), 64'(n * NUM_PE - int'(drop && n != 0)));
      check_eq("pe_weight", 64'(pe_weight), 64'(exp_w));
      if (n == 0) begin
        check_eq("zero_ready_cycles", 64'(rdy_cyc), 64'd0);
        check_eq("zero_pe_en_cycles", 64'(en_cyc), 64'd0);
      end
`ifdef PE_CHAIN_SCHED_PERF_EN
      check_eq("perf_stalls", 64'(perf_stalls), 64'(stall_cyc));
      check_eq("perf_cycles", 64'(perf_cycles), 64'(busy_cyc));
`endif
    end
    drop_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_pix = '0;
    w_valid = 1'b0; w_data = '0; px_valid = 1'b0; px_data = '0;
    drop_req = 1'b0; exp_w = '0;
    strobes = 0; rdy_cyc = 0; en_cyc = 0; stall_cyc = 0; busy_cyc = 0; done_cnt = 0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'({done, done_mismatch}), 64'd0);
    check_eq("rst_ready", 64'({w_ready, px_ready}), 64'd0);
    check_eq("rst_pe_en", 64'(pe_en), 64'd0);
    check_eq("rst_pe_weight", 64'(pe_weight), 64'd0);
    check_eq("rst_pe_input", 64'(pe_input), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    run_job(3, 1'b0, 1'b0, 0, 1'b0, 0);
    run_job(3, 1'b1, 1'b0, 0, 1'b0, 4);
    run_job(0, 1'b0, 1'b0, 0, 1'b0, 0);
    run_job(3, 1'b0, 1'b0, 1, 1'b0, 20);
    run_job(3, 1'b0, 1'b0, 0, 1'b0, 0);
    run_job(3, 1'b0, 1'b1, 0, 1'b0, 8);
    run_job(5, 1'b1, 1'b0, 0, 1'b1, 40);

    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_pix_left", 64'(pix_q.size()), 64'd0);
    check_eq("sb_done_left", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
